uart_pkt_parser: RTL and testbench
==================================

UART_PKT_PARSER -- requirements
Module: uart_pkt_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16: largest legal payload length in bytes, range 1..255.
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 4340: maximum idle clocks allowed between bytes inside a frame (20 bit times at CLKS_PER_BIT 217).
REQ-003 SHALL have port i_Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_Rst_L, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port i_RX_DV, input, 1 bit: one-cycle strobe from the UART receiver marking a received byte.
REQ-006 SHALL have port i_RX_Byte, input, 8 bits: received byte, valid while i_RX_DV=1.
REQ-007 SHALL have port o_Data_DV, output, 1 bit: one-cycle strobe per forwarded payload byte.
REQ-008 SHALL have port o_Data_Byte, output, 8 bits: payload byte, valid while o_Data_DV=1.
REQ-009 SHALL have port o_Data_Last, output, 1 bit: high together with o_Data_DV on the final payload byte.
REQ-010 SHALL have port o_Pkt_Done, output, 1 bit: one-cycle strobe when a frame completes with a good checksum.
REQ-011 SHALL have port o_Pkt_Err, output, 1 bit: one-cycle strobe when a frame is aborted.
REQ-012 SHALL have port o_Err_Code, output, 2 bits: abort cause, valid with o_Pkt_Err (01 bad length, 10 checksum mismatch, 11 timeout).
REQ-013 SHALL have port o_Busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 Frame format SHALL be SOF byte 0xA5, then LEN, then LEN payload bytes, then CHK, where CHK is the XOR of LEN and all payload bytes.
REQ-015 The FSM SHALL have four states: IDLE, LEN, PAYLOAD, CHECK.
REQ-016 IDLE: an i_RX_DV with byte 0xA5 SHALL move to LEN; every other byte SHALL be ignored with no output activity.
REQ-017 LEN: if LEN is 0 or greater than MAX_LEN, SHALL pulse o_Pkt_Err with code 01 and return to IDLE; otherwise SHALL latch LEN, seed the XOR accumulator with LEN, clear the payload counter and move to PAYLOAD.
REQ-018 PAYLOAD: each byte SHALL be forwarded on o_Data_Byte with o_Data_DV, XORed into the accumulator, and counted; o_Data_Last SHALL be set on byte number LEN, followed by a move to CHECK.
REQ-019 In PAYLOAD, byte value 0xA5 SHALL be treated as ordinary data and SHALL NOT resynchronise the frame.
REQ-020 CHECK: a byte equal to the accumulator SHALL pulse o_Pkt_Done; any other value SHALL pulse o_Pkt_Err with code 10; both cases SHALL return to IDLE.
REQ-021 All outputs SHALL be registered; each response SHALL appear exactly 1 clock after the i_RX_DV cycle that causes it.
REQ-022 Payload bytes are forwarded before the checksum is known; downstream SHALL discard the frame on o_Pkt_Err.
REQ-023 Timeout counter SHALL clear on every i_RX_DV and on entry to IDLE, and SHALL increment every clock outside IDLE.
REQ-024 When the timeout counter reaches TIMEOUT_CLKS-1 with no i_RX_DV, SHALL pulse o_Pkt_Err with code 11 and return to IDLE.
REQ-025 If i_RX_DV arrives in the same cycle the counter reaches TIMEOUT_CLKS-1, the byte SHALL win and no timeout SHALL occur.
REQ-026 o_Pkt_Done and o_Pkt_Err SHALL never be high in the same cycle; o_Err_Code SHALL hold its last value when o_Pkt_Err=0.
REQ-027 Payload counter SHALL be 8 bits wide and SHALL NOT wrap, since LEN is at most 255.

Reset
REQ-028 While i_Rst_L=0: state SHALL be IDLE, all outputs 0, and the accumulator, counters and latched LEN cleared, independent of i_Clk.
REQ-029 Reset asserted mid-frame SHALL abandon the frame silently, with no o_Pkt_Err pulse.
REQ-030 After reset release, the first action taken SHALL be on the next i_RX_DV.

Verification
REQ-031 Send A5 03 11 22 33 03 -> o_Data_DV with 11, 22, 33; Last high on 33; o_Pkt_Done 1 clock after CHK; o_Pkt_Err never high.
REQ-032 Send A5 03 11 22 33 04 -> three data strobes, then o_Pkt_Err with code 10 and no o_Pkt_Done.
REQ-033 Send A5 00, then A5 11 (MAX_LEN=16) -> two o_Pkt_Err pulses with code 01 and no data strobes.
REQ-034 Send A5 02 AA, then idle TIMEOUT_CLKS clocks -> o_Pkt_Err with code 11 and o_Busy=0; then send A5 01 5A 5B -> data 5A with Last, then o_Pkt_Done.
REQ-035 Send A5 02 A5 A5 02 -> data A5, A5 with Last on the second, then o_Pkt_Done.
REQ-036 Assert i_Rst_L=0 mid-payload -> all outputs 0 immediately and o_Busy=0; after release, bytes 37 3F produce no output.

Source files
------------

// File: rtl/uart_pkt_parser.sv
// Frame parser for a byte stream from a UART receiver: SOF 0xA5, LEN, payload, XOR checksum.
// Forwards payload bytes as they arrive and reports completion, length/checksum errors and inter-byte timeouts.
module uart_pkt_parser #(
  parameter int MAX_LEN      = 16,
  parameter int TIMEOUT_CLKS = 4340
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_Data_DV,
  output logic [7:0] o_Data_Byte,
  output logic       o_Data_Last,
  output logic       o_Pkt_Done,
  output logic       o_Pkt_Err,
  output logic [1:0] o_Err_Code,
  output logic       o_Busy
);

  localparam int              TW        = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [7:0]      SOF       = 8'hA5;
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
  localparam logic [1:0]      ERR_LEN   = 2'b01;
  localparam logic [1:0]      ERR_CHK   = 2'b10;
  localparam logic [1:0]      ERR_TMO   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LEN     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CHECK   = 2'd3
  } state_t;

  function automatic logic [7:0] chk_accum(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

  state_t        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    acc_q, acc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    cnt_nxt;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          data_dv_q, data_dv_d;
  logic [7:0]    data_byte_q, data_byte_d;
  logic          data_last_q, data_last_d;
  logic          pkt_done_q, pkt_done_d;
  logic          pkt_err_q, pkt_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          busy_q, busy_d;

  assign cnt_nxt = cnt_q + 8'd1;

  // Next-state and next-output logic; a byte strobe always takes priority over the timeout.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    data_dv_d   = 1'b0;
    data_byte_d = data_byte_q;
    data_last_d = 1'b0;
    pkt_done_d  = 1'b0;
    pkt_err_d   = 1'b0;
    err_code_d  = err_code_q;
    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (i_RX_DV && (i_RX_Byte == SOF)) begin
          state_d = S_LEN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        if (i_RX_DV) begin
          tmo_d = '0;
          case (state_q)
            S_LEN: begin
              if ((i_RX_Byte == 8'd0) || (i_RX_Byte > MAX_LEN_B)) begin
                pkt_err_d  = 1'b1;
                err_code_d = ERR_LEN;
                state_d    = S_IDLE;
              end else begin
                len_d   = i_RX_Byte;
                acc_d   = i_RX_Byte;
                cnt_d   = 8'd0;
                state_d = S_PAYLOAD;
              end
            end
            S_PAYLOAD: begin
              data_dv_d   = 1'b1;
              data_byte_d = i_RX_Byte;
              acc_d       = chk_accum(acc_q, i_RX_Byte);
              cnt_d       = cnt_nxt;
              if (cnt_nxt == len_q) begin
                data_last_d = 1'b1;
                state_d     = S_CHECK;
              end else begin
                state_d = S_PAYLOAD;
              end
            end
            S_CHECK: begin
              if (i_RX_Byte == acc_q) begin
                pkt_done_d = 1'b1;
              end else begin
                pkt_err_d  = 1'b1;
                err_code_d = ERR_CHK;
              end
              state_d = S_IDLE;
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          pkt_err_d  = 1'b1;
          err_code_d = ERR_TMO;
          tmo_d      = '0;
          state_d    = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset drops any frame in progress without reporting it.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= S_IDLE;
      len_q       <= 8'd0;
      acc_q       <= 8'd0;
      cnt_q       <= 8'd0;
      tmo_q       <= '0;
      data_dv_q   <= 1'b0;
      data_byte_q <= 8'd0;
      data_last_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      data_dv_q   <= data_dv_d;
      data_byte_q <= data_byte_d;
      data_last_q <= data_last_d;
      pkt_done_q  <= pkt_done_d;
      pkt_err_q   <= pkt_err_d;
      err_code_q  <= err_code_d;
      busy_q      <= busy_d;
    end
  end

  assign o_Data_DV   = data_dv_q;
  assign o_Data_Byte = data_byte_q;
  assign o_Data_Last = data_last_q;
  assign o_Pkt_Done  = pkt_done_q;
  assign o_Pkt_Err   = pkt_err_q;
  assign o_Err_Code  = err_code_q;
  assign o_Busy      = busy_q;

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Scoreboard bench for uart_pkt_parser: stimulus pushes expected events with their due cycle,
// a negedge monitor pops and compares every output strobe.
module tb_uart_pkt_parser;

  localparam int MAX_LEN = 16;
  localparam int T       = 4340;

  localparam int K_DATA = 1;
  localparam int K_DONE = 2;
  localparam int K_ERR  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       data_dv, data_last, pkt_done, pkt_err, busy;
  logic [7:0] data_byte;
  logic [1:0] err_code;

  int cyc = 0;
  int last_cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int         kind;
    logic [7:0] b;
    logic       last;
    logic [1:0] code;
    int         due;
  } ev_t;

  ev_t sb_q[$];

  uart_pkt_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(T)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
    .o_Data_DV(data_dv), .o_Data_Byte(data_byte), .o_Data_Last(data_last),
    .o_Pkt_Done(pkt_done), .o_Pkt_Err(pkt_err), .o_Err_Code(err_code), .o_Busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] enc(input int kind, input logic [7:0] b, input logic last,
                                      input logic [1:0] code);
    return {8'(kind), b, 7'd0, last, 6'd0, code};
  endfunction

  task automatic expect_ev(input int kind, input logic [7:0] b, input logic last, input logic [1:0] code,
                           input int due);
    ev_t e;
    e.kind = kind; e.b = b; e.last = last; e.code = code; e.due = due;
    sb_q.push_back(e);
  endtask

  // Called at a negedge; the byte is sampled at the next posedge, so its response is due at cyc+1.
  task automatic exp_data(input logic [7:0] b, input logic last);
    expect_ev(K_DATA, b, last, 2'b00, cyc + 1);
  endtask

  task automatic exp_done();
    expect_ev(K_DONE, 8'h00, 1'b0, 2'b00, cyc + 1);
  endtask

  task automatic exp_err(input logic [1:0] code);
    expect_ev(K_ERR, 8'h00, 1'b0, code, cyc + 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv    = 1'b1;
    rx_byte  = b;
    last_cyc = cyc;
    @(negedge clk);
    rx_dv = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_compare(input string name, input logic [31:0] act);
    ev_t e;
    if (sb_q.size() == 0) begin
      check({name, "_unexpected"}, act, 32'h0);
    end else begin
      e = sb_q.pop_front();
      check(name, act, enc(e.kind, e.b, e.last, e.code));
      check({name, "_latency"}, 32'(cyc), 32'(e.due));
    end
  endtask

  // Monitor: every output strobe must match the head of the scoreboard at its due cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pkt_done && pkt_err) check("done_err_exclusive", 32'h1, 32'h0);
      if (data_dv)  pop_compare("data", enc(K_DATA, data_byte, data_last, 2'b00));
      if (pkt_done) pop_compare("done", enc(K_DONE, 8'h00, 1'b0, 2'b00));
      if (pkt_err)  pop_compare("err",  enc(K_ERR, 8'h00, 1'b0, err_code));
    end
  end

  initial begin
    #1;
    check("reset_outputs", {data_dv, data_byte, data_last, pkt_done, pkt_err, err_code, busy}, 32'h0);
    idle(3);
    rst_n = 1'b1;
    idle(2);
    check("busy_after_reset", 32'(busy), 32'h0);

    // good frame 03 11 22 33, checksum 03
    send_byte(8'hA5);
    check("busy_in_frame", 32'(busy), 32'h1);
    send_byte(8'h03);
    exp_data(8'h11, 1'b0); send_byte(8'h11);
    exp_data(8'h22, 1'b0); send_byte(8'h22);
    exp_data(8'h33, 1'b1); send_byte(8'h33);
    exp_done();            send_byte(8'h03);
    check("busy_after_done", 32'(busy), 32'h0);
    idle(3);

    // same frame with a bad checksum
    send_byte(8'hA5); send_byte(8'h03);
    exp_data(8'h11, 1'b0); send_byte(8'h11);
    exp_data(8'h22, 1'b0); send_byte(8'h22);
    exp_data(8'h33, 1'b1); send_byte(8'h33);
    exp_err(2'b10);        send_byte(8'h04);
    idle(3);
    check("err_code_hold", 32'(err_code), 32'h2);

    // garbage in IDLE is ignored
    send_byte(8'h00); send_byte(8'h5A); send_byte(8'hFF);
    idle(2);

    // zero length and length MAX_LEN+1
    send_byte(8'hA5); exp_err(2'b01); send_byte(8'h00);
    send_byte(8'hA5); exp_err(2'b01); send_byte(8'h11);
    idle(2);

    // length exactly MAX_LEN is legal: bytes 01..10, checksum 10^(01^..^10)=10^10=00
    send_byte(8'hA5); send_byte(8'h10);
    for (int i = 1; i <= MAX_LEN; i++) begin
      exp_data(8'(i), (i == MAX_LEN) ? 1'b1 : 1'b0);
      send_byte(8'(i));
    end
    exp_done(); send_byte(8'h00);
    idle(2);

    // timeout mid-payload, then recovery
    send_byte(8'hA5); send_byte(8'h02);
    exp_data(8'hAA, 1'b0); send_byte(8'hAA);
    expect_ev(K_ERR, 8'h00, 1'b0, 2'b11, last_cyc + T + 1);
    idle(T + 2);
    check("busy_after_timeout", 32'(busy), 32'h0);
    send_byte(8'hA5); send_byte(8'h01);
    exp_data(8'h5A, 1'b1); send_byte(8'h5A);
    exp_done(); send_byte(8'h5B);
    idle(2);

    // byte arriving on the last allowed clock wins over the timeout
    send_byte(8'hA5); send_byte(8'h01);
    idle(T - 2);
    exp_data(8'h5A, 1'b1); send_byte(8'h5A);
    exp_done(); send_byte(8'h5B);
    idle(2);

    // byte one clock too late: timeout fires and the late byte is ignored in IDLE
    send_byte(8'hA5); send_byte(8'h01);
    expect_ev(K_ERR, 8'h00, 1'b0, 2'b11, last_cyc + T + 1);
    idle(T - 1);
    send_byte(8'h5A);
    idle(3);

    // 0xA5 inside the payload is plain data
    send_byte(8'hA5); send_byte(8'h02);
    exp_data(8'hA5, 1'b0); send_byte(8'hA5);
    exp_data(8'hA5, 1'b1); send_byte(8'hA5);
    exp_done(); send_byte(8'h02);
    idle(2);

    // reset mid-payload: immediate clear, no error pulse, no output afterwards
    send_byte(8'hA5); send_byte(8'h04);
    exp_data(8'h11, 1'b0); send_byte(8'h11);
    check("busy_before_reset", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {data_dv, data_byte, data_last, pkt_done, pkt_err, err_code, busy}, 32'h0);
    idle(3);
    rst_n = 1'b1;
    send_byte(8'h37); send_byte(8'h3F);
    idle(T + 5);
    check("busy_after_reset_release", 32'(busy), 32'h0);

    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
